// File: rtl/trng_arbiter.sv
// Round-robin arbiter that shares one 32-bit TRNG word source among N_REQ requesters,
// with a watchdog on the TRNG handshake. Define TRNG_ARB_HEALTH_EN to add a repetition health test.
module trng_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         rand_valid,
    output logic [31:0]              rand_data,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err,
`ifdef TRNG_ARB_HEALTH_EN
    output logic                     health_fail,
`endif
    output logic                     trng_request,
    input  logic                     trng_ready,
    input  logic [31:0]              trng_number
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DELIVER = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0] valid_q, valid_d;
    logic [31:0]    data_q, data_d;
    logic           treq_q, treq_d;
    logic           tout_q, tout_d;

    logic           repeat_hit;
    logic           retry_q;

    logic           pick_vld;
    logic [GW-1:0]  pick_idx;
    logic [GW-1:0]  cand;
    logic [GW-1:0]  nxt_grant;

    // Scan downward so the candidate closest to rr_q (lowest offset) is the last one written.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_q;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_q) + k) % N_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign nxt_grant = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        valid_d = '0;
        data_d  = data_q;
        tout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // A ready on the expiry cycle still completes the handshake.
                if (trng_ready) begin
                    if (repeat_hit) begin
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_DELIVER;
                        if (req[grant_q]) begin
                            valid_d[grant_q] = 1'b1;
                            data_d           = trng_number;
                        end
                    end
                end else if (cnt_d == CW'(TIMEOUT_CYC)) begin
                    tout_d  = 1'b1;
                    rr_d    = nxt_grant;
                    state_d = S_RELEASE;
                end
            end
            S_DELIVER: begin
                rr_d    = nxt_grant;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Hold off until the TRNG drops ready so a stale word cannot finish the next request.
                if (!trng_ready) begin
                    if (retry_q && req[grant_q]) begin
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                        if (retry_q) rr_d = nxt_grant;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        treq_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
            treq_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            treq_q  <= treq_d;
            tout_q  <= tout_d;
        end
    end

`ifdef TRNG_ARB_HEALTH_EN
    logic [31:0] last_q, last_d;
    logic        hfail_q, hfail_d;
    logic        retry_d;

    assign repeat_hit = (trng_number == last_q);

    always_comb begin
        last_d  = last_q;
        hfail_d = hfail_q;
        retry_d = retry_q;
        if (state_q == S_REQ && trng_ready) begin
            last_d = trng_number;
            if (repeat_hit) begin
                hfail_d = 1'b1;
                retry_d = 1'b1;
            end
        end
        if (state_q == S_RELEASE && !trng_ready) retry_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= '0;
            hfail_q <= 1'b0;
            retry_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            hfail_q <= hfail_d;
            retry_q <= retry_d;
        end
    end

    assign health_fail = hfail_q;
`else
    assign repeat_hit = 1'b0;
    assign retry_q    = 1'b0;
`endif

    assign rand_valid   = valid_q;
    assign rand_data    = data_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q != S_IDLE);
    assign timeout_err  = tout_q;
    assign trng_request = treq_q;

endmodule

// File: tb/tb_trng_arbiter.sv
// Bench for trng_arbiter: directed scenarios plus randomized traffic against a
// transaction-phase reference model; build with TRNG_ARB_HEALTH_EN to cover the health test.
module tb_trng_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
`ifdef TRNG_ARB_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] rand_valid;
    logic [31:0]  rand_data;
    logic [1:0]   grant_id;
    logic         busy, timeout_err, trng_request;
    logic         trng_ready = 1'b0;
    logic [31:0]  trng_number = '0;
`ifdef TRNG_ARB_HEALTH_EN
    logic         health_fail;
`endif

    always #5 clk = ~clk;

    trng_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .rand_valid(rand_valid), .rand_data(rand_data), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err),
`ifdef TRNG_ARB_HEALTH_EN
        .health_fail(health_fail),
`endif
        .trng_request(trng_request), .trng_ready(trng_ready), .trng_number(trng_number)
    );

    int total = 0;
    int bad = 0;

    // reference model: phase 0 idle, 1 waiting on TRNG, 2 delivering, 3 draining ready
    int           ph = 0, mg = 0, mrr = 0, mcnt = 0;
    logic [31:0]  mdata = '0, mlast = '0;
    logic [N-1:0] mvld = '0;
    bit           mto = 0, mhf = 0, mretry = 0;

    // sampled DUT outputs
    logic [N-1:0] s_valid;
    logic [31:0]  s_data;
    logic [1:0]   s_grant;
    logic         s_busy, s_to, s_treq, s_hf;

    // TRNG responder
    bit           tr_rdy = 0, tr_never = 0;
    int           tr_lat = 2, tr_wcnt = 0, tr_hold = 0, tr_xhold = 0;
    logic [31:0]  tr_num = '0, tr_prev = '0;
    logic [31:0]  wq[$];

    bit           rnd_mode = 0;
    logic [N-1:0] req_v = '0;
    int           pulse_log[$];
    logic [31:0]  data_log[$];
    int           to_cnt = 0, treq_hi = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    task automatic mreset();
        ph = 0; mg = 0; mrr = 0; mcnt = 0;
        mdata = '0; mlast = '0; mvld = '0;
        mto = 0; mhf = 0; mretry = 0;
    endtask

    task automatic model_adv();
        logic [N-1:0] nv;
        bit nt, found;
        nv = '0; nt = 0; found = 0;
        case (ph)
            0: if (req != '0) begin
                for (int k = 0; k < N; k++)
                    if (!found && bitof(req, (mrr + k) % N)) begin found = 1; mg = (mrr + k) % N; end
                ph = 1; mcnt = 0;
            end
            1: if (trng_ready) begin
                if (HEALTH && trng_number == mlast) begin
                    mhf = 1; mretry = 1; ph = 3;
                end else begin
                    ph = 2;
                    if (bitof(req, mg)) begin mdata = trng_number; nv = N'(1) << mg; end
                end
                mlast = trng_number;
            end else begin
                mcnt++;
                if (mcnt == TO) begin nt = 1; mrr = (mg + 1) % N; ph = 3; end
            end
            2: begin mrr = (mg + 1) % N; ph = 3; end
            default: if (!trng_ready) begin
                if (mretry) begin
                    mretry = 0;
                    if (bitof(req, mg)) begin ph = 1; mcnt = 0; end
                    else begin ph = 0; mrr = (mg + 1) % N; end
                end else ph = 0;
            end
        endcase
        mvld = nv; mto = nt;
    endtask

    // Runs at a falling edge: compare, drive next inputs, advance the model.
    task automatic cycle_body();
        logic [N-1:0] m;
        logic [31:0] w;
        int r;
        s_valid = rand_valid; s_data = rand_data; s_grant = grant_id;
        s_busy = busy; s_to = timeout_err; s_treq = trng_request;
`ifdef TRNG_ARB_HEALTH_EN
        s_hf = health_fail;
        chk("health_fail", 64'(s_hf), 64'(mhf));
`else
        s_hf = 1'b0;
`endif
        chk("busy", 64'(s_busy), 64'(ph != 0));
        chk("trng_request", 64'(s_treq), 64'(ph == 1));
        chk("grant_id", 64'(s_grant), 64'(mg));
        chk("rand_valid", 64'(s_valid), 64'(mvld));
        chk("rand_data", 64'(s_data), 64'(mdata));
        chk("timeout_err", 64'(s_to), 64'(mto));
        for (int i = 0; i < N; i++)
            if (bitof(s_valid, i)) begin pulse_log.push_back(i); data_log.push_back(s_data); end
        if (s_to) to_cnt++;
        if (s_treq) treq_hi++;

        if (rnd_mode)
            for (int i = 0; i < N; i++) begin
                m = N'(1) << i;
                if ((req_v & m) == '0) begin
                    if ($urandom_range(0, 3) == 0) req_v = req_v | m;
                end else if ((s_valid & m) != '0) begin
                    if ($urandom_range(0, 1) == 0) req_v = req_v & ~m;
                end else if ($urandom_range(0, 63) == 0) req_v = req_v & ~m;
            end
        req = req_v;

        if (tr_rdy) begin
            if (!s_treq) begin
                if (tr_hold > 0) tr_hold--;
                else tr_rdy = 0;
            end
        end else if (s_treq) begin
            if (tr_wcnt == 0 && rnd_mode) begin
                r = int'($urandom_range(0, 11));
                tr_never = (r == 0);
                tr_lat = (r == 1) ? TO : (r == 2) ? TO - 1 : int'($urandom_range(1, 4));
                tr_xhold = int'($urandom_range(0, 2));
            end
            tr_wcnt++;
            if (!tr_never && tr_wcnt >= tr_lat) begin
                if (wq.size() > 0) w = wq.pop_front();
                else if ($urandom_range(0, 5) == 0) w = tr_prev;
                else w = $urandom;
                tr_rdy = 1; tr_wcnt = 0; tr_hold = tr_xhold; tr_num = w; tr_prev = w;
            end
        end else tr_wcnt = 0;
        trng_ready = tr_rdy;
        trng_number = tr_rdy ? tr_num : $urandom;
        model_adv();
    endtask

    task automatic step();
        @(negedge clk);
        cycle_body();
    endtask

    task automatic tr_clear();
        tr_rdy = 0; tr_wcnt = 0; tr_hold = 0; trng_ready = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_trng_request", 64'(trng_request), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rand_valid", 64'(rand_valid), 64'(0));
        chk("rst_rand_data", 64'(rand_data), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_timeout_err", 64'(timeout_err), 64'(0));
        mreset();
        tr_clear();
        @(negedge clk);
        rst_n = 1'b1;
        cycle_body();
    endtask

    task automatic wait_pulses(input string nm, input int cnt, input int budget, output int n);
        n = 0;
        while (pulse_log.size() < cnt && n < budget) begin step(); n++; end
        chk(nm, 64'(pulse_log.size() >= cnt), 64'(1));
    endtask

    task automatic wait_idle(input string nm, input int budget, output int n);
        n = 0;
        do begin step(); n++; end while (s_busy && n < budget);
        chk(nm, 64'(s_busy), 64'(0));
    endtask

    task automatic wait_treq(input string nm, input int budget);
        int n;
        n = 0;
        do begin step(); n++; end while (!s_treq && n < budget);
        chk(nm, 64'(s_treq), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_guard simulation did not finish at %0t", $time);
        $fatal(1, "global guard expired");
    end

    initial begin
        int n;
        mreset();
        repeat (2) @(negedge clk);
        chk("init_trng_request", 64'(trng_request), 64'(0));
        chk("init_busy", 64'(busy), 64'(0));
        chk("init_rand_valid", 64'(rand_valid), 64'(0));
        chk("init_rand_data", 64'(rand_data), 64'(0));
        rst_n = 1'b1;
        cycle_body();

        // single requester, word after 10 request cycles
        tr_lat = 10; tr_xhold = 0; tr_never = 0;
        wq.push_back(32'hDEADBEEF);
        req_v = 4'b0001;
        pulse_log.delete(); data_log.delete();
        wait_pulses("single_bound", 1, 40, n);
        chk("single_latency", 64'(n), 64'(12));
        chk("single_valid", 64'(s_valid), 64'(4'b0001));
        chk("single_data", 64'(s_data), 64'(32'hDEADBEEF));
        req_v = '0;
        wait_idle("single_idle", 10, n);
        chk("single_release_len", 64'(n), 64'(2));

        // async reset while in REQ, then fairness with all requesting
        tr_lat = 8;
        req_v = 4'b0100;
        repeat (4) step();
        chk("pre_reset_treq", 64'(s_treq), 64'(1));
        req_v = 4'b1111; tr_lat = 2;
        pulse_log.delete(); data_log.delete();
        do_reset();
        wait_pulses("rr_bound", 5, 80, n);
        for (int i = 0; i < 5; i++)
            if (i < pulse_log.size()) chk($sformatf("rr_order%0d", i), 64'(pulse_log[i]), 64'(i % N));
        req_v = '0;
        wait_idle("rr_idle", 20, n);

        // watchdog: requester 2 never answered, requester 3 arrives meanwhile
        pulse_log.delete(); data_log.delete();
        to_cnt = 0; treq_hi = 0; tr_never = 1;
        req_v = 4'b0100;
        repeat (3) step();
        req_v = 4'b1100;
        n = 0;
        while (to_cnt == 0 && n < 40) begin step(); n++; end
        chk("to_seen", 64'(to_cnt), 64'(1));
        chk("to_req_cycles", 64'(treq_hi), 64'(16));
        chk("to_no_valid", 64'(pulse_log.size()), 64'(0));
        tr_never = 0; tr_lat = 2;
        wq.push_back(32'hCAFEF00D);
        wait_treq("to_next_req", 20);
        chk("to_next_grant", 64'(s_grant), 64'(3));
        wait_pulses("to_next_bound", 1, 20, n);
        if (pulse_log.size() > 0) chk("to_next_pulse", 64'(pulse_log[0]), 64'(3));
        chk("to_next_data", 64'(s_data), 64'(32'hCAFEF00D));
        req_v = '0;
        wait_idle("to_idle", 20, n);
        chk("to_single_pulse", 64'(to_cnt), 64'(1));

        // withdrawal during REQ
        pulse_log.delete(); data_log.delete();
        tr_lat = 3;
        wq.push_back(32'h12345678);
        req_v = 4'b0010;
        repeat (2) step();
        req_v = '0;
        wait_idle("wd_idle", 20, n);
        chk("wd_no_valid", 64'(pulse_log.size()), 64'(0));
        chk("wd_data_kept", 64'(s_data), 64'(32'hCAFEF00D));
        req_v = 4'b1111;
        wait_treq("wd_next_req", 10);
        chk("wd_rr_ptr", 64'(s_grant), 64'(2));
        req_v = '0;
        wait_idle("wd_idle2", 20, n);

        // ready arrives on the very cycle the watchdog would expire
        pulse_log.delete(); data_log.delete();
        to_cnt = 0; treq_hi = 0; tr_lat = TO;
        req_v = 4'b0001;
        wait_pulses("edge_bound", 1, 40, n);
        if (pulse_log.size() > 0) chk("edge_pulse", 64'(pulse_log[0]), 64'(0));
        chk("edge_no_timeout", 64'(to_cnt), 64'(0));
        chk("edge_req_cycles", 64'(treq_hi), 64'(16));
        req_v = '0;
        wait_idle("edge_idle", 20, n);

`ifdef TRNG_ARB_HEALTH_EN
        // repeated word is withheld and the same requester is re-served
        tr_lat = 2;
        req_v = 4'b0001;
        pulse_log.delete(); data_log.delete();
        do_reset();
        wq.push_back(32'hA5A5A5A5); wq.push_back(32'hA5A5A5A5); wq.push_back(32'h0F0F0F0F);
        wait_pulses("hl_bound", 2, 80, n);
        if (data_log.size() > 1) begin
            chk("hl_first", 64'(data_log[0]), 64'(32'hA5A5A5A5));
            chk("hl_third", 64'(data_log[1]), 64'(32'h0F0F0F0F));
            chk("hl_grant", 64'(pulse_log[1]), 64'(0));
        end
        chk("hl_fail_flag", 64'(s_hf), 64'(1));
        req_v = '0;
        wait_idle("hl_idle", 20, n);
`endif

        // randomized traffic
        pulse_log.delete(); data_log.delete();
        rnd_mode = 1;
        repeat (4000) step();
        rnd_mode = 0;
        req_v = '0; tr_never = 0; tr_lat = 2; tr_xhold = 0;
        wait_idle("rand_idle", 60, n);
        chk("rand_activity", 64'(pulse_log.size() > 20), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trng_arbiter.md
Name: trng_arbiter

Overview:
- Shares the single 32-bit TRNG word generator between N_REQ requesters (crypto cores, key/nonce generators).
- Sequences the TRNG request/ready handshake.
- Selects requesters round-robin.
- Enforces a watchdog timeout.
- Returns each word to exactly one requester with a one-cycle valid pulse.
- Sits between the crypto cores and the TRNG unit. It is the only driver of the TRNG request line.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYC, 1024, cycles allowed in REQ before abort; counter width $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  level request per requester; held until its valid pulse
- rand_valid  out  N_REQ  one-hot, one-cycle pulse; the word on rand_data belongs to the pulsed requester
- rand_data  out  32  last delivered random word; holds between deliveries
- grant_id  out  $clog2(N_REQ)  index of the current or last winner
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a request
- trng_request  out  1  to TRNG; level, held until trng_ready is seen
- trng_ready  in  1  from TRNG; high while a word is valid; TRNG clears it one cycle after trng_request falls
- trng_number  in  32  word from TRNG; valid while trng_ready=1

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; rr_ptr=0.
  - All outputs 0: rand_valid, rand_data, grant_id, busy, timeout_err, trng_request.
  - Timeout counter 0.
- IDLE:
  - If req has any bit set, choose the first set bit scanning upward from rr_ptr, wrapping at N_REQ-1 to 0.
  - Latch it into grant_id and go to REQ.
  - trng_request=1 from the first REQ cycle.
  - No request: stay in IDLE.
- REQ:
  - trng_request=1; the timeout counter increments each cycle.
  - trng_ready=1 → capture trng_number, go to DELIVER, trng_request=0.
  - Counter reaches TIMEOUT_CYC with no trng_ready → trng_request=0, timeout_err pulses 1 cycle, go to RELEASE. No valid pulse is issued.
- DELIVER (exactly 1 cycle):
  - If req[grant_id] is still 1: rand_data=captured word and rand_valid[grant_id]=1.
  - If the winner withdrew during REQ: word discarded, no pulse, rand_data unchanged.
  - rr_ptr=(grant_id+1) mod N_REQ in every case.
  - Go to RELEASE.
- RELEASE:
  - Wait until trng_ready=0, then go to IDLE.
  - This prevents a stale ready from completing the next request.
  - Minimum 1 cycle.
- Latency: req seen in IDLE → trng_request at +1. trng_ready high at cycle T → rand_valid at T+1.
- Back-to-back:
  - Minimum 4 cycles between grants (IDLE, REQ, DELIVER, RELEASE) with an immediate ready.
  - A requester still asserting req after its pulse is treated as a new request. It loses priority to other pending requesters.
- Simultaneous events:
  - New req bits arriving outside IDLE are ignored until the next IDLE.
  - trng_ready on the same cycle the timeout expires: ready wins and the word is delivered.
- Reset mid-operation: immediate return to the reset state; trng_request drops asynchronously.
- rand_valid is never multi-hot. At most one word is delivered per TRNG handshake.

Optional Feature:
- Macro: TRNG_ARB_HEALTH_EN
- Defined:
  - Adds a continuous repetition test. Each captured word is compared with the previous captured word (last_word, reset to 0).
  - On a match:
    - The word is discarded and no rand_valid is issued.
    - health_fail (extra output, 1 bit, sticky) is set.
    - The FSM goes to RELEASE, then straight back to REQ for the same grant_id. rr_ptr does not advance.
    - The retry proceeds only if the winner is still requesting. Otherwise it goes to IDLE and rr_ptr advances.
  - health_fail clears only on reset.
  - last_word updates on every capture.
- Not defined:
  - No comparison and no last_word register.
  - The health_fail port is absent.

Test Plan:
- Single requester: req=4'b0001, TRNG returns 32'hDEADBEEF after 10 cycles → rand_valid=4'b0001 one cycle later, rand_data=32'hDEADBEEF, then RELEASE until trng_ready=0, then busy=0.
- Round-robin fairness: req=4'b1111 held, TRNG ready in 2 cycles each time → grant order 0,1,2,3,0, each with exactly one single-cycle pulse.
- Timeout: TIMEOUT_CYC=16, req=4'b0100, trng_ready held 0 → trng_request falls after 16 cycles, timeout_err pulses once, no rand_valid, next grant goes to requester 3 if pending.
- Withdrawal: req[1] drops while in REQ, TRNG returns 32'h12345678 → no rand_valid, rand_data unchanged, rr_ptr=2.
- Async reset mid-REQ: rst_n low for 1 cycle → trng_request=0 immediately, all outputs 0, a new request is granted to index 0 first.
- TRNG_ARB_HEALTH_EN defined: TRNG returns 32'hA5A5A5A5 twice → second word withheld, health_fail=1, re-request to the same grant_id; a third word 32'h0F0F0F0F is delivered.
